// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multi-cycle RISC-V control unit: opcodes,
// ALU operation codes, FSM states and datapath select encodings.
package multicycle_control_fsm_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,  ALU_SUB  = 4'd1,  ALU_SLL  = 4'd2,  ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,  ALU_XOR  = 4'd5,  ALU_SRL  = 4'd6,  ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,  ALU_AND  = 4'd9,  ALU_BNE  = 4'd10, ALU_BLT  = 4'd11,
    ALU_BGE  = 4'd12, ALU_BLTU = 4'd13, ALU_BGEU = 4'd14
  } aluop_t;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_EXEC_R, S_EXEC_I, S_EXEC_LUI, S_ALU_WB, S_BRANCH, S_JAL, S_TRAP
  } state_t;

  // Which decode table the ALU op decoder applies in the current state.
  typedef enum logic [1:0] {DEC_ADD, DEC_ALU, DEC_BRANCH} dec_sel_t;

  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLDPC  = 2'b01;
  localparam logic [1:0] SRCA_RS1    = 2'b10;
  localparam logic [1:0] SRCA_ZERO   = 2'b11;

  localparam logic [1:0] SRCB_RS2    = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALURES  = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  function automatic logic [2:0] imm_sel(input logic [6:0] opcode);
    case (opcode)
      OP_STORE:         return IMM_S;
      OP_BRANCH:        return IMM_B;
      OP_JAL:           return IMM_J;
      OP_LUI, OP_AUIPC: return IMM_U;
      default:          return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_alu_op_decoder.sv
// Combinational ALU operation decoder: arithmetic/logic ops for R/I types,
// comparison ops for branches, plain ADD for address/PC arithmetic.
module alu_op_decoder
  import multicycle_control_fsm_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  dec_sel_t   sel,
  output aluop_t     alu_op,
  output logic       branch_illegal
);

  always_comb begin
    alu_op         = ALU_ADD;
    branch_illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
    case (sel)
      DEC_ALU: begin
        case (funct3)
          3'b000:  alu_op = ((opcode == OP_R) && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_op = ALU_SLL;
          3'b010:  alu_op = ALU_SLT;
          3'b011:  alu_op = ALU_SLTU;
          3'b100:  alu_op = ALU_XOR;
          3'b101:  alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end
      DEC_BRANCH: begin
        case (funct3)
          3'b000:  alu_op = ALU_SUB;
          3'b001:  alu_op = ALU_BNE;
          3'b100:  alu_op = ALU_BLT;
          3'b101:  alu_op = ALU_BGE;
          3'b110:  alu_op = ALU_BLTU;
          3'b111:  alu_op = ALU_BGEU;
          default: alu_op = ALU_ADD;
        endcase
      end
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RISC-V control unit: sequences fetch/decode/execute/memory/
// writeback, drives datapath selects and the shared memory handshake.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int unsigned ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        instr,
  input  logic               zero,
  input  logic               mem_ready,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         result_src,
  output logic [2:0]         imm_src,
  output logic               adr_src,
  output logic               pc_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic               mem_req,
  output logic               mem_we,
  output logic               illegal_instr
);

  state_t     state, state_nx;
  dec_sel_t   dec_sel;
  aluop_t     dec_op;
  logic       br_illegal;
  logic       br_taken;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_instr_bits;

  assign opcode            = instr[6:0];
  assign funct3            = instr[14:12];
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  alu_op_decoder u_alu_op_decoder (
    .opcode         (opcode),
    .funct3         (funct3),
    .funct7_5       (instr[30]),
    .sel            (dec_sel),
    .alu_op         (dec_op),
    .branch_illegal (br_illegal)
  );

  assign alu_op = ALUOP_W'(dec_op);

  // Gated so that the whole output set reads zero while reset is held.
  assign imm_src = rst_n ? imm_sel(opcode) : IMM_I;

  // BEQ compares via SUB and BNE yields 1 on equality, so both take on zero.
  assign br_taken = ((funct3 == 3'b000) || (funct3 == 3'b001)) ? zero : ~zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    dec_sel       = DEC_ADD;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    result_src    = RES_ALUOUT;
    adr_src       = 1'b0;
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    illegal_instr = 1'b0;
    case (state)
      S_IDLE: state_nx = S_FETCH;
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
        pc_write   = mem_ready;
        ir_write   = mem_ready;
        if (mem_ready) state_nx = S_FETCH == state ? S_DECODE : state;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: state_nx = S_MEM_ADDR;
          OP_R:              state_nx = S_EXEC_R;
          OP_I:              state_nx = S_EXEC_I;
          OP_BRANCH:         state_nx = br_illegal ? S_TRAP : S_BRANCH;
          OP_JAL:            state_nx = S_JAL;
          OP_LUI:            state_nx = S_EXEC_LUI;
          OP_AUIPC:          state_nx = S_ALU_WB;
          default:           state_nx = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        state_nx  = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_nx = S_MEM_WB;
      end
      S_MEM_WB: begin
        result_src = RES_MEMDATA;
        reg_write  = 1'b1;
        state_nx   = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_nx = S_FETCH;
      end
      S_EXEC_R: begin
        dec_sel   = DEC_ALU;
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        state_nx  = S_ALU_WB;
      end
      S_EXEC_I: begin
        dec_sel   = DEC_ALU;
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        state_nx  = S_ALU_WB;
      end
      S_EXEC_LUI: begin
        alu_src_a = SRCA_ZERO;
        alu_src_b = SRCB_IMM;
        state_nx  = S_ALU_WB;
      end
      S_ALU_WB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        state_nx   = S_FETCH;
      end
      S_BRANCH: begin
        dec_sel    = DEC_BRANCH;
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        result_src = RES_ALUOUT;
        pc_write   = br_taken;
        state_nx   = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
        state_nx   = S_ALU_WB;
      end
      S_TRAP: begin
        illegal_instr = 1'b1;
        state_nx      = S_TRAP;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed self-checking bench for multicycle_control_fsm: outputs are
// sampled one time unit after the falling edge and compared to hand values.
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic [3:0]  alu_op;
  logic [1:0]  alu_src_a, alu_src_b, result_src;
  logic [2:0]  imm_src;
  logic        adr_src, pc_write, ir_write, reg_write, mem_req, mem_we, illegal_instr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.ALUOP_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr         (instr),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .alu_op        (alu_op),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .result_src    (result_src),
    .imm_src       (imm_src),
    .adr_src       (adr_src),
    .pc_write      (pc_write),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .illegal_instr (illegal_instr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Packed order: alu_op, src_a, src_b, result_src, adr, pcw, irw, rw, req, we, ill
  task automatic expect_o(input string tag, input logic [3:0] op,
                          input logic [1:0] a, input logic [1:0] b, input logic [1:0] rs,
                          input logic adr, input logic pcw, input logic irw, input logic rw,
                          input logic req, input logic we, input logic ill);
    #1;
    chk(tag,
        {15'b0, alu_op, alu_src_a, alu_src_b, result_src, adr_src, pc_write,
         ir_write, reg_write, mem_req, mem_we, illegal_instr},
        {15'b0, op, a, b, rs, adr, pcw, irw, rw, req, we, ill});
  endtask

  task automatic exp_zero(input string tag);
    expect_o(tag, 4'd0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic exp_fetch(input string tag, input logic rdy);
    expect_o(tag, 4'd0, 2'b00, 2'b10, 2'b10, 0, rdy, rdy, 0, 1, 0, 0);
  endtask

  task automatic exp_decode(input string tag);
    expect_o(tag, 4'd0, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic exp_alu_wb(input string tag);
    expect_o(tag, 4'd0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 0);
  endtask

  // One full branch instruction: FETCH, DECODE, BRANCH with the given zero flag.
  task automatic run_branch(input string tag, input logic [31:0] ins, input logic z,
                            input logic [3:0] op, input logic taken);
    @(negedge clk); instr = ins; mem_ready = 1; zero = 0;
    exp_fetch({tag, "_fetch"}, 1);
    @(negedge clk); exp_decode({tag, "_decode"});
    chk({tag, "_imm_src"}, {29'b0, imm_src}, 32'd2);
    @(negedge clk); zero = z;
    expect_o({tag, "_branch"}, op, 2'b10, 2'b00, 2'b00, 0, taken, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0; instr = 32'h0020A023; zero = 0; mem_ready = 0;
    @(negedge clk); exp_zero("reset_outputs");
    chk("reset_imm_src", {29'b0, imm_src}, 32'd0);
    @(negedge clk); rst_n = 1; exp_zero("idle_after_release");

    // add x3,x1,x2
    @(negedge clk); instr = 32'h002081B3; mem_ready = 1; exp_fetch("add_fetch", 1);
    @(negedge clk); exp_decode("add_decode");
    @(negedge clk); expect_o("add_exec_r", 4'd0, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); exp_alu_wb("add_alu_wb");
    // sub x3,x1,x2 ; fetched in cycle 5 of the add
    @(negedge clk); instr = 32'h402081B3; exp_fetch("add_refetch_c5", 1);
    @(negedge clk); exp_decode("sub_decode");
    @(negedge clk); expect_o("sub_exec_r", 4'd1, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); exp_alu_wb("sub_alu_wb");
    // srai x3,x1,5
    @(negedge clk); instr = 32'h4050D193; exp_fetch("srai_fetch", 1);
    @(negedge clk); exp_decode("srai_decode");
    @(negedge clk); expect_o("srai_exec_i", 4'd7, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); exp_alu_wb("srai_alu_wb");
    // addi x1,x0,-1 : instr[30]=1 must not turn ADDI into SUB
    @(negedge clk); instr = 32'hFFF00093; exp_fetch("addi_fetch", 1);
    @(negedge clk); exp_decode("addi_decode");
    @(negedge clk); expect_o("addi_exec_i", 4'd0, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); exp_alu_wb("addi_alu_wb");

    // lw x5,0(x1) with three memory wait cycles
    @(negedge clk); instr = 32'h0000A283; exp_fetch("lw_fetch", 1);
    @(negedge clk); exp_decode("lw_decode");
    chk("lw_imm_src", {29'b0, imm_src}, 32'd0);
    @(negedge clk); expect_o("lw_mem_addr", 4'd0, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk); mem_ready = 0;
      expect_o("lw_mem_read_wait", 4'd0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 1, 0, 0);
    end
    @(negedge clk); mem_ready = 1;
    expect_o("lw_mem_read_ready", 4'd0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 1, 0, 0);
    @(negedge clk); expect_o("lw_mem_wb", 4'd0, 2'b00, 2'b00, 2'b01, 0, 0, 0, 1, 0, 0, 0);

    // sw x2,0(x1) with one memory wait cycle
    @(negedge clk); instr = 32'h0020A023; exp_fetch("sw_fetch", 1);
    @(negedge clk); exp_decode("sw_decode");
    chk("sw_imm_src", {29'b0, imm_src}, 32'd1);
    @(negedge clk); expect_o("sw_mem_addr", 4'd0, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); mem_ready = 0;
    expect_o("sw_mem_write_wait", 4'd0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 1, 1, 0);
    @(negedge clk); mem_ready = 1;
    expect_o("sw_mem_write_ready", 4'd0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 1, 1, 0);

    run_branch("beq_z1", 32'h00208463, 1, 4'd1,  1);
    run_branch("beq_z0", 32'h00208463, 0, 4'd1,  0);
    run_branch("bne_z1", 32'h00209463, 1, 4'd10, 1);
    run_branch("bne_z0", 32'h00209463, 0, 4'd10, 0);
    run_branch("blt_z0", 32'h0020C463, 0, 4'd11, 1);

    // jal x1,8
    @(negedge clk); instr = 32'h008000EF; zero = 0; exp_fetch("jal_fetch", 1);
    @(negedge clk); exp_decode("jal_decode");
    chk("jal_imm_src", {29'b0, imm_src}, 32'd3);
    @(negedge clk); expect_o("jal_jal", 4'd0, 2'b01, 2'b10, 2'b00, 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk); exp_alu_wb("jal_alu_wb");
    // lui x1,0x12345
    @(negedge clk); instr = 32'h123450B7; exp_fetch("lui_fetch", 1);
    @(negedge clk); exp_decode("lui_decode");
    chk("lui_imm_src", {29'b0, imm_src}, 32'd4);
    @(negedge clk); expect_o("lui_exec", 4'd0, 2'b11, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); exp_alu_wb("lui_alu_wb");
    // auipc x1,1 : three-cycle instruction
    @(negedge clk); instr = 32'h00001097; exp_fetch("auipc_fetch", 1);
    @(negedge clk); exp_decode("auipc_decode");
    @(negedge clk); exp_alu_wb("auipc_alu_wb");

    // illegal opcode -> TRAP, held regardless of mem_ready
    @(negedge clk); instr = 32'hFFFFFFFF; exp_fetch("auipc_refetch_c4", 1);
    @(negedge clk); exp_decode("ill_decode");
    for (int unsigned i = 0; i < 20; i++) begin
      @(negedge clk); mem_ready = i[0];
      expect_o("ill_trap_hold", 4'd0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1);
    end
    rst_n = 0; exp_zero("ill_reset_clears");
    @(negedge clk); rst_n = 1; mem_ready = 0; exp_zero("ill_reset_idle");
    @(negedge clk); exp_fetch("after_trap_fetch_wait", 0);

    // reset asserted mid-cycle while FETCH is waiting on memory
    @(negedge clk); exp_fetch("fetch_wait_held", 0);
    #1; rst_n = 0; exp_zero("async_reset_drops_req");
    @(negedge clk); rst_n = 1; exp_zero("post_reset_idle");
    @(negedge clk); mem_ready = 1; instr = 32'h0020A463; exp_fetch("post_reset_fetch", 1);

    // branch with reserved funct3 = 010
    @(negedge clk); exp_decode("bad_branch_decode");
    @(negedge clk); expect_o("bad_branch_trap", 4'd0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
